// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter (sll/srl/sra/ror), one bit position per clock.
// Operands are captured on start; busy covers the whole operation and done pulses once with the result.
module serial_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5   // must equal $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

  state_t             r_state;
  op_t                r_op;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   w_step;

  // One-position step of the data register for the latched operation.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_step unassigned (no latch).
    w_step = r_data;
    unique case (r_op)
      OP_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
      OP_SRL: w_step = {1'b0, r_data[WIDTH-1:1]};
      OP_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      OP_ROR: w_step = {r_data[0], r_data[WIDTH-1:1]};
      default: w_step = r_data;
    endcase
  end

  // busy and done are registered alongside the state, so they follow it with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SLL;
      r_data  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data  <= data_in;
            r_count <= shamt;
            r_op    <= op_t'(op);
            r_busy  <= 1'b1;
            if (shamt == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_data  <= w_step;
          r_count <= r_count - COUNT_ONE;
          // Leaving at count==1 means the counter never wraps below zero.
          if (r_count == COUNT_ONE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_data;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: expected results queued at start, compared on each done pulse.
module tb_serial_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [31:0] sb[$];

  serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Scoreboard side: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("result", result, sb.pop_front());
    end
  end

  // Drives one request, then watches latency, busy length and the single done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] sh, input logic [31:0] exp);
    int lat, bcnt, d0;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; data_in = d; shamt = sh;
    sb.push_back(exp);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); data_in = $urandom; shamt = 5'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(int'(sh) + 1));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(int'(sh) + 1));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_held"}, result, exp);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    bit seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run_op("sll2",   2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004);
    run_op("srl31",  2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("sra_neg",2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
    run_op("sra_pos",2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF);
    run_op("ror1",   2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000);
    run_op("zero",   2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);

    // Second start mid-SHIFT must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; data_in = 32'h1; shamt = 5'd8;
    sb.push_back(32'h0000_0100);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; data_in = 32'hA5A5_5A5A; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("ignore_done_seen", 32'(seen), 32'd1);
    repeat (12) @(negedge clk);
    check("ignore_done_count", 32'(done_cnt - d0), 32'd1);
    check("ignore_held", result, 32'h0000_0100);
    check("ignore_idle", 32'(busy), 32'd0);

    // Reset asserted in the 5th SHIFT cycle: everything clears, no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b01; data_in = 32'hF0F0_F0F0; shamt = 5'd10;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_still_idle", 32'(busy), 32'd0);

    run_op("srl16", 2'b01, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_shift_unit.md
Name: serial_shift_unit

Overview:
- Multi-cycle shifter for the processor datapath.
- Covers the right-shift direction (srl, sra, rotate right) and also sll, one bit position per clock.
- Operands are captured on a start pulse; the unit asserts busy while working and pulses done when the result is valid.
- Sits beside the ALU and serves shift-class R-type instructions. Control stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  operation: 00 sll, 01 srl, 10 sra, 11 ror
- data_in  input  WIDTH  operand to shift
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  WIDTH  shifted value; held until the next accepted start

Behaviour:
- Interface rule: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous assertion): state=IDLE; internal data register, count, op register = 0; busy=0, done=0, result=0.
- States: IDLE, SHIFT, DONE. busy and done are Moore outputs; result is driven directly from the data register.
- IDLE:
  - On a rising edge with start=1: latch data_in into the data register, shamt into the count, op into the op register.
  - Next state is DONE if shamt==0, else SHIFT.
  - start=0: remain in IDLE, registers hold.
- SHIFT, each rising edge:
  - Data register shifts by exactly one position; count decrements by 1.
  - If count==1 before the decrement, next state is DONE; otherwise stay in SHIFT.
- One-bit step per op:
  - sll: {d[W-2:0], 0}
  - srl: {0, d[W-1:1]}
  - sra: {d[W-1], d[W-1:1]}
  - ror: {d[0], d[W-1:1]}
- DONE: done=1 and busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: if start is sampled at edge E, done is high in the cycle following edge E+shamt.
  - shamt=0: done in the cycle after the sampling edge.
  - shamt=31: 32 busy cycles total.
- start while busy (SHIFT or DONE) is ignored, with no queuing. start held high through DONE is accepted at the first IDLE edge.
- Inputs data_in, op and shamt are don't-care except at the accepting edge; changes mid-operation have no effect.
- result holds the final value after done until the next accepted start. The data register reloads at that edge, so result then shows the new operand.
- Reset asserted mid-operation: immediate return to reset values, no done pulse. Resumption after reset needs a new start.
- No arithmetic beyond the count decrement. Count never wraps because the transition to DONE occurs at count==1.

Test Plan:
- Reset, then sll, data_in=0x00000001, shamt=2 -> busy high for 3 cycles; done in the cycle after edge E+2; result=0x00000004.
- srl, data_in=0x80000000, shamt=31 -> done after edge E+31; result=0x00000001; busy high 32 consecutive cycles.
- sra, data_in=0x80000000, shamt=4 -> result=0xF8000000. Then sra, data_in=0x7FFFFFF0, shamt=4 -> result=0x07FFFFFF.
- ror, data_in=0x00000001, shamt=1 -> result=0x80000000. Then any op with data_in=0xDEADBEEF, shamt=0 -> done in the cycle after the sampling edge; result=0xDEADBEEF.
- Start sll, data_in=0x1, shamt=8; pulse start again mid-SHIFT with other operands -> second request ignored; result=0x00000100 and exactly one done pulse.
- Start srl, shamt=10; drop rst_n at the 5th SHIFT cycle -> busy, done, result = 0 immediately with no done pulse. After release, srl of 0xFFFFFFFF by 16 -> result=0x0000FFFF.
